// File: rtl/multiword_addsub_if.sv
// Request/result bus for multiword_addsub: start handshake with operands,
// done handshake with full-width result and flags.
interface multiword_addsub_if #(
    parameter int unsigned WORDS = 2
);
    localparam int unsigned W = 32 * WORDS;

    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         sub_mode;
    logic         carry_in;
    logic         done_valid;
    logic         done_ready;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    modport master (
        output start_valid, op_a, op_b, sub_mode, carry_in, done_ready,
        input  start_ready, done_valid, result, carry_out, overflow, zero
    );

    modport slave (
        input  start_valid, op_a, op_b, sub_mode, carry_in, done_ready,
        output start_ready, done_valid, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/multiword_addsub.sv
// Sequential WORDS x 32-bit add/subtract engine around one rca_32bit, LS word first.
// Optional zero flag built only when MWAS_ZERO_FLAG_EN is defined.
module rca_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    input  logic        subtract_mode,
    output logic [31:0] sum,
    output logic        carry_out
);
    logic [31:0] b_eff;

    always_comb begin
        b_eff                = b ^ {32{subtract_mode}};
        {carry_out, sum}     = {1'b0, a} + {1'b0, b_eff} + 33'(carry_in ^ subtract_mode);
    end
endmodule

module multiword_addsub #(
    parameter int unsigned WORDS = 2
) (
    input  logic               clk,
    input  logic               rst,
    multiword_addsub_if.slave  bus
);
    localparam int unsigned W    = 32 * WORDS;
    localparam int unsigned KW   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [KW-1:0] LAST = KW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  result_q, result_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;
    logic          start_ready_q, start_ready_d;
    logic          done_valid_q, done_valid_d;

    logic [31:0]   a_w, b_w, sum_w;
    logic          co_w;

    // Select the current word of A and B' for the adder.
    always_comb begin
        a_w = '0;
        b_w = '0;
        for (int unsigned w = 0; w < WORDS; w++) begin
            if (k_q == KW'(w)) begin
                a_w = a_q[w*32 +: 32];
                b_w = b_q[w*32 +: 32];
            end
        end
    end

    rca_32bit u_rca (
        .a             (a_w),
        .b             (b_w),
        .carry_in      (carry_q),
        .subtract_mode (1'b0),
        .sum           (sum_w),
        .carry_out     (co_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            k_q           <= '0;
            a_q           <= '0;
            b_q           <= '0;
            carry_q       <= 1'b0;
            result_q      <= '0;
            cout_q        <= 1'b0;
            ovf_q         <= 1'b0;
            start_ready_q <= 1'b1;
            done_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            a_q           <= a_d;
            b_q           <= b_d;
            carry_q       <= carry_d;
            result_q      <= result_d;
            cout_q        <= cout_d;
            ovf_q         <= ovf_d;
            start_ready_q <= start_ready_d;
            done_valid_q  <= done_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        a_d           = a_q;
        b_d           = b_q;
        carry_d       = carry_q;
        result_d      = result_q;
        cout_d        = cout_q;
        ovf_d         = ovf_q;
        start_ready_d = 1'b0;
        done_valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Subtraction is A + ~B + ~borrow_in on a plain adder.
                if (bus.start_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.sub_mode ? ~bus.op_b : bus.op_b;
                    carry_d = bus.sub_mode ? ~bus.carry_in : bus.carry_in;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned w = 0; w < WORDS; w++) begin
                    if (k_q == KW'(w)) begin
                        result_d[w*32 +: 32] = sum_w;
                    end
                end
                carry_d = co_w;
                k_d     = k_q + KW'(1);
                if (k_q == LAST) begin
                    k_d     = '0;
                    cout_d  = co_w;
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum_w[31] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.done_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        start_ready_d = (state_d == IDLE);
        done_valid_d  = (state_d == DONE);
    end

    assign bus.start_ready = start_ready_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.result      = result_q;
    assign bus.carry_out   = cout_q;
    assign bus.overflow    = ovf_q;

`ifdef MWAS_ZERO_FLAG_EN
    logic zacc_q;
    logic zero_q;

    // Accumulate "every word so far was zero"; publish with the last word.
    always_ff @(posedge clk) begin
        if (rst) begin
            zacc_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (state_q == IDLE && bus.start_valid) begin
            zacc_q <= 1'b1;
        end else if (state_q == RUN) begin
            zacc_q <= zacc_q & (sum_w == 32'd0);
            if (k_q == LAST) begin
                zero_q <= zacc_q & (sum_w == 32'd0);
            end
        end
    end

    assign bus.zero = zero_q;
`else
    assign bus.zero = 1'b0;
`endif
endmodule

// File: tb/tb_multiword_addsub.sv
// Randomized and directed bench for multiword_addsub (WORDS=2) against an
// arithmetic reference model.
module tb_multiword_addsub;
    localparam int unsigned WORDS = 2;
    localparam int unsigned W     = 32 * WORDS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multiword_addsub_if #(.WORDS(WORDS)) bus ();

    multiword_addsub #(.WORDS(WORDS)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_res;
    logic         exp_co;
    logic         exp_ov;
    logic         exp_z;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact-integer reference: carry/borrow and signed range computed directly.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic sub, input logic cin);
        logic [W:0]   t;
        logic [W+1:0] sa, sb, s;
        sa = {{2{a[W-1]}}, a};
        sb = {{2{b[W-1]}}, b};
        if (!sub) begin
            t      = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            exp_co = t[W];
            s      = sa + sb + (W+2)'(cin);
        end else begin
            t      = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
            exp_co = ~t[W];
            s      = sa - sb - (W+2)'(cin);
        end
        exp_res = t[W-1:0];
        exp_ov  = (s[W+1:W-1] != 3'b000) && (s[W+1:W-1] != 3'b111);
`ifdef MWAS_ZERO_FLAG_EN
        exp_z   = (exp_res == '0);
`else
        exp_z   = 1'b0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sub, input logic cin);
        int n = 0;
        while (bus.start_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("start_wait", W'(n < 20), W'(1));
        bus.op_a        = a;
        bus.op_b        = b;
        bus.sub_mode    = sub;
        bus.carry_in    = cin;
        bus.start_valid = 1'b1;
        model(a, b, sub, cin);
        tick();
        bus.start_valid = 1'b0;
    endtask

    task automatic finish_op(input string tag);
        int lat = 1;
        while (bus.done_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, W'(lat), W'(WORDS + 1));
        check({tag, "_res"}, bus.result, exp_res);
        check({tag, "_co"},  W'(bus.carry_out), W'(exp_co));
        check({tag, "_ov"},  W'(bus.overflow),  W'(exp_ov));
        check({tag, "_z"},   W'(bus.zero),      W'(exp_z));
    endtask

    task automatic release_op();
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        check("rel_sready", W'(bus.start_ready), W'(1));
        check("rel_dvalid", W'(bus.done_valid),  W'(0));
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
        start_op(a, b, sub, cin);
        finish_op(tag);
        release_op();
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           nd;

        rst             = 1'b1;
        bus.start_valid = 1'b0;
        bus.op_a        = '0;
        bus.op_b        = '0;
        bus.sub_mode    = 1'b0;
        bus.carry_in    = 1'b0;
        bus.done_ready  = 1'b0;
        tick();
        tick();
        check("rst_sready", W'(bus.start_ready), W'(1));
        check("rst_dvalid", W'(bus.done_valid),  W'(0));
        check("rst_res",    bus.result,          W'(0));
        check("rst_co",     W'(bus.carry_out),   W'(0));
        check("rst_ov",     W'(bus.overflow),    W'(0));
        check("rst_z",      W'(bus.zero),        W'(0));
        rst = 1'b0;
        tick();

        run_op("add_carry", 64'h00000000_FFFFFFFF, 64'h1, 1'b0, 1'b0);
        run_op("add_ovf",   64'h7FFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0);
        run_op("add_wrap",  64'hFFFFFFFF_FFFFFFFF, 64'h1, 1'b0, 1'b0);
        run_op("sub_pos",   64'h5, 64'h3, 1'b1, 1'b0);
        run_op("sub_neg",   64'h3, 64'h5, 1'b1, 1'b0);
        run_op("sub_bin",   64'h5, 64'h3, 1'b1, 1'b1);
        run_op("sub_ovf",   64'h80000000_00000000, 64'h1, 1'b1, 1'b0);
        run_op("add_cin",   64'hFFFFFFFF_FFFFFFFE, 64'h1, 1'b0, 1'b1);

        // Back-pressure: result must hold and new requests must wait.
        start_op(64'h12345678_9ABCDEF0, 64'h0FEDCBA9_87654321, 1'b0, 1'b0);
        finish_op("hold");
        bus.op_a        = 64'h1;
        bus.op_b        = 64'h1;
        bus.sub_mode    = 1'b1;
        bus.carry_in    = 1'b0;
        bus.start_valid = 1'b1;
        repeat (5) begin
            tick();
            check("hold_res",    bus.result,          exp_res);
            check("hold_co",     W'(bus.carry_out),   W'(exp_co));
            check("hold_ov",     W'(bus.overflow),    W'(exp_ov));
            check("hold_sready", W'(bus.start_ready), W'(0));
            check("hold_dvalid", W'(bus.done_valid),  W'(1));
        end
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        check("hold_rel_sready", W'(bus.start_ready), W'(1));
        model(64'h1, 64'h1, 1'b1, 1'b0);
        tick();
        bus.start_valid = 1'b0;
        check("hold_acc_sready", W'(bus.start_ready), W'(0));
        finish_op("hold_next");
        release_op();

        // Reset in the first RUN cycle aborts the operation.
        start_op(64'hDEADBEEF_CAFEF00D, 64'h11111111_11111111, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_sready", W'(bus.start_ready), W'(1));
        check("abort_dvalid", W'(bus.done_valid),  W'(0));
        check("abort_res",    bus.result,          W'(0));
        check("abort_co",     W'(bus.carry_out),   W'(0));
        check("abort_ov",     W'(bus.overflow),    W'(0));
        check("abort_z",      W'(bus.zero),        W'(0));
        nd = 0;
        repeat (8) begin
            tick();
            if (bus.done_valid === 1'b1) nd++;
        end
        check("abort_nodone", W'(nd), W'(0));

        for (int i = 0; i < 40; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = ~a;
                default: ;
            endcase
            start_op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            finish_op("rand");
            repeat ($urandom_range(0, 3)) tick();
            check("rand_hold", bus.result, exp_res);
            release_op();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
